// File: rtl/picosoc_sdram_arbiter.sv
// rtl/picosoc_sdram_arbiter.sv - two-port SDRAM request arbiter with per-access wait timeout
// ARBITER_ROUND_ROBIN_EN selects round-robin on simultaneous requests; undefined gives fixed p0 priority.
module picosoc_sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_logic,
  input  logic        system_reset,
  input  logic        p0_valid,
  input  logic [3:0]  p0_wstrb,
  input  logic [20:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [3:0]  p1_wstrb,
  input  logic [20:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic [20:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_byte_en,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        mem_burst,
  input  logic [31:0] mem_q,
  input  logic        mem_ready,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [8:0]  wait_cnt_q, wait_cnt_d;
  logic [20:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  byte_en_q, byte_en_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        timeout_err_q, timeout_err_d;
  logic        win_p1;
  logic [3:0]  win_wstrb;
  logic        done;
  logic        forced;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_q, last_d;
  // On a tie the port that did not win last time goes first.
  assign win_p1 = p1_valid && (!p0_valid || !last_q);
`else
  assign win_p1 = p1_valid && !p0_valid;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    wait_cnt_d    = wait_cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    byte_en_d     = byte_en_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    timeout_err_d = timeout_err_q;
    done          = 1'b0;
    forced        = 1'b0;
    win_wstrb     = win_p1 ? p1_wstrb : p0_wstrb;
`ifdef ARBITER_ROUND_ROBIN_EN
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (p0_valid || p1_valid) begin
          grant_d    = win_p1;
          addr_d     = win_p1 ? p1_addr : p0_addr;
          data_d     = win_p1 ? p1_wdata : p0_wdata;
          byte_en_d  = win_wstrb;
          wr_d       = |win_wstrb;
          rd_d       = ~|win_wstrb;
          wait_cnt_d = 9'd0;
          state_d    = BUSY;
`ifdef ARBITER_ROUND_ROBIN_EN
          last_d     = win_p1;
`endif
        end
      end
      BUSY: begin
        if (mem_ready) begin
          done = 1'b1;
        end else if (wait_cnt_q >= TIMEOUT_LIM) begin
          done   = 1'b1;
          forced = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 9'd1;
        end
        // The access finishes even if its requester has gone away; only ready is withheld.
        if (done) begin
          wr_d          = 1'b0;
          rd_d          = 1'b0;
          state_d       = RELEASE;
          timeout_err_d = timeout_err_q | forced;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      wait_cnt_q    <= 9'd0;
      addr_q        <= 21'd0;
      data_q        <= 32'd0;
      byte_en_q     <= 4'd0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      wait_cnt_q    <= wait_cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      byte_en_q     <= byte_en_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      timeout_err_q <= timeout_err_d;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_q        <= last_d;
`endif
    end
  end

  assign p0_ready    = done && !grant_q && p0_valid;
  assign p1_ready    = done && grant_q && p1_valid;
  assign p0_rdata    = forced ? 32'hFFFF_FFFF : mem_q;
  assign p1_rdata    = forced ? 32'hFFFF_FFFF : mem_q;
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign mem_byte_en = byte_en_q;
  assign mem_wr      = wr_q;
  assign mem_rd      = rd_q;
  assign mem_burst   = 1'b0;
  assign timeout_err = timeout_err_q;

endmodule
